// File: rtl/alu_share_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// alu_ctrl_pkg
// Shared types for the ALU-sharing controller:
//   alu_op_e  - 3-bit opcode encoding understood by alu4_core
//   state_e   - controller FSM states
//   CARRY/ZERO - bit positions inside the 2-bit {carry, zero} flag vector
// -----------------------------------------------------------------------------
package alu_ctrl_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_AND = 3'd2,
      OP_OR  = 3'd3,
      OP_XOR = 3'd4,
      OP_NOT = 3'd5,
      OP_SHL = 3'd6,
      OP_SHR = 3'd7
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam int CARRY = 1;
   localparam int ZERO  = 0;

endpackage

// File: rtl/alu_share_ctrl_if.sv
// -----------------------------------------------------------------------------
// alu_share_ctrl_if
// Bundles the two request channels (valid/ready + op/a/b) and the two
// response channels (valid/ready + data/flags) of the ALU-sharing controller.
//   master - requester side (drives requests, accepts responses)
//   slave  - controller side
// -----------------------------------------------------------------------------
interface alu_share_ctrl_if #(
   parameter int W = 4
);
   logic         req0_valid, req1_valid;
   logic         req0_ready, req1_ready;
   logic [2:0]   req0_op, req1_op;
   logic [W-1:0] req0_a, req0_b, req1_a, req1_b;

   logic         rsp0_valid, rsp1_valid;
   logic         rsp0_ready, rsp1_ready;
   logic [W-1:0] rsp0_data, rsp1_data;
   logic [1:0]   rsp0_flags, rsp1_flags;

   modport master (
      output req0_valid, req1_valid, req0_op, req1_op,
             req0_a, req0_b, req1_a, req1_b, rsp0_ready, rsp1_ready,
      input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
             rsp0_data, rsp1_data, rsp0_flags, rsp1_flags
   );

   modport slave (
      input  req0_valid, req1_valid, req0_op, req1_op,
             req0_a, req0_b, req1_a, req1_b, rsp0_ready, rsp1_ready,
      output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
             rsp0_data, rsp1_data, rsp0_flags, rsp1_flags
   );
endinterface

// File: rtl/alu_share_ctrl_alu4_core.sv
// -----------------------------------------------------------------------------
// alu4_core
// Purely combinational W-bit ALU.
//   op     - opcode (alu_op_e)
//   a, b   - operands
//   result - op(a, b) modulo 2^W
//   flags  - {carry, zero}; carry is carry-out (ADD), borrow (SUB),
//            shifted-out bit (SHL/SHR), else 0
// -----------------------------------------------------------------------------
module alu4_core
   import alu_ctrl_pkg::*;
#(
   parameter int W = 4
) (
   input  alu_op_e      op,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] result,
   output logic [1:0]   flags
);
   logic [W:0] sum;
   logic       carry;

   always_comb begin
      result = '0;
      carry  = 1'b0;
      sum    = '0;
      case (op)
         OP_ADD: begin
            sum    = {1'b0, a} + {1'b0, b};
            result = sum[W-1:0];
            carry  = sum[W];
         end
         OP_SUB: begin
            result = a - b;
            carry  = (a < b);
         end
         OP_AND: result = a & b;
         OP_OR:  result = a | b;
         OP_XOR: result = a ^ b;
         OP_NOT: result = ~a;
         OP_SHL: begin
            result = {a[W-2:0], 1'b0};
            carry  = a[W-1];
         end
         OP_SHR: begin
            result = {1'b0, a[W-1:1]};
            carry  = a[0];
         end
         default: result = '0;
      endcase
      flags        = '0;
      flags[CARRY] = carry;
      flags[ZERO]  = (result == '0);
   end
endmodule

// File: rtl/alu_share_ctrl.sv
// -----------------------------------------------------------------------------
// alu_share_ctrl
// Shares one alu4_core between two requesters. Round-robin arbiter picks a
// request in IDLE, the operands are latched, the ALU is given ALU_LAT cycles
// (EXEC), and the result is held on the owner's response channel (RESP)
// until the owner takes it.
//   clk, reset - clock, synchronous active-high reset
//   ena        - global enable; 0 freezes every register
//   bus        - request/response channels (slave side)
//   busy       - registered, high whenever state != IDLE
// -----------------------------------------------------------------------------
module alu_share_ctrl
   import alu_ctrl_pkg::*;
#(
   parameter int W       = 4,
   parameter int ALU_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ena,
   alu_share_ctrl_if.slave   bus,
   output logic              busy
);
   localparam int CW = 2;

   // Per-requester views of the bus so the steering logic can be indexed.
   logic [1:0]   req_valid, rsp_ready, ready;
   logic [2:0]   op_in [2];
   logic [W-1:0] a_in  [2];
   logic [W-1:0] b_in  [2];

   assign req_valid = {bus.req1_valid, bus.req0_valid};
   assign rsp_ready = {bus.rsp1_ready, bus.rsp0_ready};
   assign op_in[0]  = bus.req0_op;
   assign op_in[1]  = bus.req1_op;
   assign a_in[0]   = bus.req0_a;
   assign a_in[1]   = bus.req1_a;
   assign b_in[0]   = bus.req0_b;
   assign b_in[1]   = bus.req1_b;

   state_e        state_reg, state_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   alu_op_e       op_reg, op_next;
   logic [W-1:0]  a_reg, a_next, b_reg, b_next;
   logic          owner_reg, owner_next;
   logic          last_grant_reg, last_grant_next;
   logic          busy_reg, busy_next;
   logic [1:0]    rsp_valid_reg, rsp_valid_next;
   logic [W-1:0]  data_reg  [2];
   logic [W-1:0]  data_next [2];
   logic [1:0]    flags_reg [2];
   logic [1:0]    flags_next[2];

   logic          grant;
   logic [W-1:0]  alu_result;
   logic [1:0]    alu_flags;

   alu4_core #(.W(W)) u_alu (
      .op     (op_reg),
      .a      (a_reg),
      .b      (b_reg),
      .result (alu_result),
      .flags  (alu_flags)
   );

   // Lone requester wins; on a tie the one not granted last wins.
   assign grant = req_valid[1] & ~(req_valid[0] & last_grant_reg);

   always_comb begin
      state_next      = state_reg;
      cnt_next        = cnt_reg;
      op_next         = op_reg;
      a_next          = a_reg;
      b_next          = b_reg;
      owner_next      = owner_reg;
      last_grant_next = last_grant_reg;
      rsp_valid_next  = rsp_valid_reg;
      data_next       = data_reg;
      flags_next      = flags_reg;
      ready           = '0;

      // reset gating keeps a reset cycle from looking like an accept upstream
      if (ena && !reset) begin
         case (state_reg)
            IDLE: begin
               ready[grant] = req_valid[grant];
               if (req_valid[grant]) begin
                  op_next         = alu_op_e'(op_in[grant]);
                  a_next          = a_in[grant];
                  b_next          = b_in[grant];
                  owner_next      = grant;
                  last_grant_next = grant;
                  cnt_next        = CW'(ALU_LAT - 1);
                  state_next      = EXEC;
               end
            end
            EXEC: begin
               if (cnt_reg == '0) begin
                  data_next[owner_reg]      = alu_result;
                  flags_next[owner_reg]     = alu_flags;
                  rsp_valid_next[owner_reg] = 1'b1;
                  state_next                = RESP;
               end else begin
                  cnt_next = cnt_reg - 2'd1;
               end
            end
            RESP: begin
               if (rsp_ready[owner_reg]) begin
                  rsp_valid_next[owner_reg] = 1'b0;
                  state_next                = IDLE;
               end
            end
            default: state_next = IDLE;
         endcase
      end
      busy_next = (state_next != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= IDLE;
         cnt_reg        <= '0;
         op_reg         <= OP_ADD;
         a_reg          <= '0;
         b_reg          <= '0;
         owner_reg      <= 1'b0;
         last_grant_reg <= 1'b1;
         busy_reg       <= 1'b0;
         rsp_valid_reg  <= '0;
      end else begin
         state_reg      <= state_next;
         cnt_reg        <= cnt_next;
         op_reg         <= op_next;
         a_reg          <= a_next;
         b_reg          <= b_next;
         owner_reg      <= owner_next;
         last_grant_reg <= last_grant_next;
         busy_reg       <= busy_next;
         rsp_valid_reg  <= rsp_valid_next;
      end
   end

   // One result/flag register pair per requester, so each channel's data
   // stays put while the other requester is being served.
   for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
      always_ff @(posedge clk) begin
         if (reset) begin
            data_reg[gi]  <= '0;
            flags_reg[gi] <= '0;
         end else begin
            data_reg[gi]  <= data_next[gi];
            flags_reg[gi] <= flags_next[gi];
         end
      end
   end

   assign bus.req0_ready = ready[0];
   assign bus.req1_ready = ready[1];
   assign bus.rsp0_valid = rsp_valid_reg[0];
   assign bus.rsp1_valid = rsp_valid_reg[1];
   assign bus.rsp0_data  = data_reg[0];
   assign bus.rsp1_data  = data_reg[1];
   assign bus.rsp0_flags = flags_reg[0];
   assign bus.rsp1_flags = flags_reg[1];
   assign busy           = busy_reg;
endmodule

// File: tb/tb_alu_share_ctrl.sv
module tb_alu_share_ctrl;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic ena1 = 1'b1;
   logic ena3 = 1'b1;
   logic busy1, busy3;

   always #5 clk = ~clk;

   alu_share_ctrl_if #(.W(4)) if1 ();
   alu_share_ctrl_if #(.W(4)) if3 ();

   alu_share_ctrl #(.W(4), .ALU_LAT(1)) dut1 (
      .clk(clk), .reset(reset), .ena(ena1), .bus(if1), .busy(busy1));
   alu_share_ctrl #(.W(4), .ALU_LAT(3)) dut3 (
      .clk(clk), .reset(reset), .ena(ena3), .bus(if3), .busy(busy3));

   typedef struct {
      int         id;
      logic [3:0] data;
      logic [1:0] flags;
   } exp_t;

   exp_t q1[$];
   exp_t q3[$];
   int checks = 0;
   int errors = 0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endfunction

   function automatic void push(bit which3, int id, logic [3:0] d, logic [1:0] f);
      exp_t e;
      e.id = id; e.data = d; e.flags = f;
      if (which3) q3.push_back(e); else q1.push_back(e);
   endfunction

   function automatic void pop_chk(bit which3, int id, logic [3:0] d, logic [1:0] f);
      exp_t e;
      string tag;
      tag = which3 ? "dut3" : "dut1";
      if ((which3 && q3.size() == 0) || (!which3 && q1.size() == 0)) begin
         checks++;
         errors++;
         $display("FAIL %s_unexpected_rsp: requester %0d data %0d flags %0d, expected no response", tag, id, d, f);
      end else begin
         e = which3 ? q3.pop_front() : q1.pop_front();
         $display("%s rsp: requester %0d data %0d flags %b", tag, id, d, f);
         chk({tag, "_rsp_owner"}, id, e.id);
         chk({tag, "_rsp_data"}, d, e.data);
         chk({tag, "_rsp_flags"}, f, e.flags);
      end
   endfunction

   // Monitor: a handshake seen at the negedge completes at the next posedge.
   always @(negedge clk) begin
      if (!reset) begin
         if (ena1) begin
            if (if1.rsp0_valid && if1.rsp1_valid) chk("dut1_two_rsp_valid", 1, 0);
            if (if1.rsp0_valid && if1.rsp0_ready) pop_chk(1'b0, 0, if1.rsp0_data, if1.rsp0_flags);
            if (if1.rsp1_valid && if1.rsp1_ready) pop_chk(1'b0, 1, if1.rsp1_data, if1.rsp1_flags);
         end
         if (ena3) begin
            if (if3.rsp0_valid && if3.rsp0_ready) pop_chk(1'b1, 0, if3.rsp0_data, if3.rsp0_flags);
            if (if3.rsp1_valid && if3.rsp1_ready) pop_chk(1'b1, 1, if3.rsp1_data, if3.rsp1_flags);
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic drive1(int n, logic v, logic [2:0] op, logic [3:0] a, logic [3:0] b);
      if (n == 0) begin
         if1.req0_valid = v; if1.req0_op = op; if1.req0_a = a; if1.req0_b = b;
      end else begin
         if1.req1_valid = v; if1.req1_op = op; if1.req1_a = a; if1.req1_b = b;
      end
   endtask

   // Waits (bounded) until requester n of dut1 is accepted, then drops valid.
   task automatic accept1(int n);
      bit got = 0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if ((n == 0) ? if1.req0_ready : if1.req1_ready) begin got = 1; break; end
         tick();
      end
      if (!got) chk("accept_timeout", 0, 1);
      tick();
      if (n == 0) if1.req0_valid = 1'b0; else if1.req1_valid = 1'b0;
   endtask

   task automatic issue1(int n, logic [2:0] op, logic [3:0] a, logic [3:0] b,
                         logic [3:0] ed, logic [1:0] ef);
      push(1'b0, n, ed, ef);
      drive1(n, 1'b1, op, a, b);
      accept1(n);
   endtask

   task automatic wait_idle1();
      bit got = 0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (!busy1 && q1.size() == 0) begin got = 1; break; end
      end
      if (!got) chk("idle_timeout", 0, 1);
      tick();
   endtask

   task automatic wait_rsp_valid(bit which3, int n);
      bit got = 0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (which3 ? ((n == 0) ? if3.rsp0_valid : if3.rsp1_valid)
                    : ((n == 0) ? if1.rsp0_valid : if1.rsp1_valid)) begin
            got = 1; break;
         end
      end
      if (!got) chk("rsp_valid_timeout", 0, 1);
      tick();
   endtask

   logic [2:0] rr_op0 [4] = '{3'd0, 3'd2, 3'd6, 3'd5};
   logic [3:0] rr_a0  [4] = '{4'd2, 4'd12, 4'd9, 4'd15};
   logic [3:0] rr_b0  [4] = '{4'd3, 4'd10, 4'd0, 4'd0};
   logic [3:0] rr_d0  [4] = '{4'd5, 4'd8, 4'd2, 4'd0};
   logic [1:0] rr_f0  [4] = '{2'b00, 2'b00, 2'b10, 2'b01};
   logic [2:0] rr_op1 [4] = '{3'd3, 3'd4, 3'd7, 3'd0};
   logic [3:0] rr_a1  [4] = '{4'd5, 4'd7, 4'd3, 4'd15};
   logic [3:0] rr_b1  [4] = '{4'd10, 4'd7, 4'd0, 4'd1};
   logic [3:0] rr_d1  [4] = '{4'd15, 4'd0, 4'd1, 4'd0};
   logic [1:0] rr_f1  [4] = '{2'b00, 2'b01, 2'b10, 2'b11};

   initial begin
      int i0, i1, cycles;
      bit a0, a1;
      if1.req0_valid = 0; if1.req1_valid = 0; if1.req0_op = 0; if1.req1_op = 0;
      if1.req0_a = 0; if1.req0_b = 0; if1.req1_a = 0; if1.req1_b = 0;
      if1.rsp0_ready = 1; if1.rsp1_ready = 1;
      if3.req0_valid = 0; if3.req1_valid = 0; if3.req0_op = 0; if3.req1_op = 0;
      if3.req0_a = 0; if3.req0_b = 0; if3.req1_a = 0; if3.req1_b = 0;
      if3.rsp0_ready = 1; if3.rsp1_ready = 1;

      // Reset with a request already pending: nothing may be accepted.
      drive1(0, 1'b1, 3'd0, 4'd9, 4'd8);
      repeat (2) tick();
      @(negedge clk);
      chk("reset_req0_ready", if1.req0_ready, 0);
      chk("reset_rsp0_valid", if1.rsp0_valid, 0);
      chk("reset_rsp1_valid", if1.rsp1_valid, 0);
      chk("reset_busy", busy1, 0);
      chk("reset_rsp0_data", if1.rsp0_data, 0);
      chk("reset_rsp0_flags", if1.rsp0_flags, 0);
      tick();
      reset = 1'b0;

      // ADD 9+8 = 17 -> data 1, carry
      push(1'b0, 0, 4'd1, 2'b10);
      @(negedge clk);
      chk("add_ready_first_edge", if1.req0_ready, 1);
      tick();
      if1.req0_valid = 1'b0;
      @(negedge clk);
      chk("add_exec_busy", busy1, 1);
      chk("add_exec_rsp0_valid", if1.rsp0_valid, 0);
      tick();
      @(negedge clk);
      chk("add_resp_rsp0_valid", if1.rsp0_valid, 1);
      chk("add_resp_rsp1_valid", if1.rsp1_valid, 0);
      tick();
      @(negedge clk);
      chk("add_done_rsp0_valid", if1.rsp0_valid, 0);
      chk("add_done_busy", busy1, 0);
      tick();

      // SUB with borrow and SUB to zero
      issue1(1, 3'd1, 4'd3, 4'd5, 4'd14, 2'b10);
      wait_idle1();
      issue1(1, 3'd1, 4'd5, 4'd5, 4'd0, 2'b01);
      wait_idle1();

      // Both requesters valid every cycle: grants must alternate 0,1,0,1...
      for (int k = 0; k < 4; k++) begin
         push(1'b0, 0, rr_d0[k], rr_f0[k]);
         push(1'b0, 1, rr_d1[k], rr_f1[k]);
      end
      i0 = 0; i1 = 0;
      for (int cyc = 0; cyc < 200 && (i0 < 4 || i1 < 4); cyc++) begin
         if (i0 < 4) drive1(0, 1'b1, rr_op0[i0], rr_a0[i0], rr_b0[i0]);
         else if1.req0_valid = 1'b0;
         if (i1 < 4) drive1(1, 1'b1, rr_op1[i1], rr_a1[i1], rr_b1[i1]);
         else if1.req1_valid = 1'b0;
         @(negedge clk);
         a0 = if1.req0_ready; a1 = if1.req1_ready;
         if (a0 && a1) chk("rr_both_ready", 1, 0);
         tick();
         if (a0) i0++;
         if (a1) i1++;
      end
      chk("rr_all_accepted", i0 + i1, 8);
      if1.req0_valid = 1'b0; if1.req1_valid = 1'b0;
      wait_idle1();

      // Response stalled 5 cycles with req1 waiting behind it.
      if1.rsp0_ready = 1'b0;
      push(1'b0, 0, 4'd7, 2'b00);
      push(1'b0, 1, 4'd3, 2'b00);
      drive1(1, 1'b1, 3'd2, 4'd15, 4'd3);
      drive1(0, 1'b1, 3'd3, 4'd6, 4'd1);
      accept1(0);
      wait_rsp_valid(1'b0, 0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("stall_rsp0_valid", if1.rsp0_valid, 1);
         chk("stall_data", if1.rsp0_data, 7);
         chk("stall_flags", if1.rsp0_flags, 0);
         chk("stall_busy", busy1, 1);
         chk("stall_req1_ready", if1.req1_ready, 0);
         tick();
      end
      if1.rsp0_ready = 1'b1;
      @(negedge clk);
      tick();
      @(negedge clk);
      chk("release_rsp0_valid", if1.rsp0_valid, 0);
      chk("release_busy", busy1, 0);
      chk("release_req1_ready", if1.req1_ready, 1);
      tick();
      if1.req1_valid = 1'b0;
      wait_idle1();

      // ALU_LAT=3: nominal latency, then 3 disabled cycles mid-EXEC.
      push(1'b1, 0, 4'd7, 2'b00);
      if3.req0_valid = 1'b1; if3.req0_op = 3'd0; if3.req0_a = 4'd3; if3.req0_b = 4'd4;
      @(negedge clk);
      chk("lat3_ready", if3.req0_ready, 1);
      tick();
      if3.req0_valid = 1'b0;
      cycles = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (if3.rsp0_valid) break;
         tick();
         cycles++;
      end
      chk("lat3_nominal", cycles, 3);
      repeat (2) tick();

      push(1'b1, 0, 4'd5, 2'b00);
      if3.req0_valid = 1'b1; if3.req0_op = 3'd1; if3.req0_a = 4'd9; if3.req0_b = 4'd4;
      @(negedge clk);
      chk("lat3_ena_ready", if3.req0_ready, 1);
      tick();
      if3.req0_valid = 1'b0;
      cycles = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (if3.rsp0_valid) break;
         tick();
         cycles++;
         if (cycles == 1) ena3 = 1'b0;
         if (cycles == 4) ena3 = 1'b1;
      end
      chk("lat3_ena_delayed", cycles, 6);
      ena3 = 1'b1;
      repeat (2) tick();

      // ena low in IDLE with a request valid: no ready until ena returns.
      push(1'b1, 1, 4'd9, 2'b00);
      ena3 = 1'b0;
      if3.req1_valid = 1'b1; if3.req1_op = 3'd3; if3.req1_a = 4'd8; if3.req1_b = 4'd1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("ena_low_req1_ready", if3.req1_ready, 0);
         tick();
      end
      ena3 = 1'b1;
      @(negedge clk);
      chk("ena_high_req1_ready", if3.req1_ready, 1);
      tick();
      if3.req1_valid = 1'b0;
      wait_rsp_valid(1'b1, 1);
      repeat (2) tick();

      // Reset during RESP drops the pending result; req0 then wins the tie.
      if1.rsp0_ready = 1'b0;
      drive1(0, 1'b1, 3'd0, 4'd4, 4'd4);
      accept1(0);
      wait_rsp_valid(1'b0, 0);
      reset = 1'b1;
      if1.rsp0_ready = 1'b1;
      drive1(0, 1'b1, 3'd0, 4'd1, 4'd1);
      drive1(1, 1'b1, 3'd0, 4'd2, 4'd2);
      @(negedge clk);
      chk("rst_cycle_req0_ready", if1.req0_ready, 0);
      tick();
      @(negedge clk);
      chk("rst_resp_rsp0_valid", if1.rsp0_valid, 0);
      chk("rst_resp_rsp1_valid", if1.rsp1_valid, 0);
      chk("rst_resp_busy", busy1, 0);
      chk("rst_resp_data", if1.rsp0_data, 0);
      tick();
      reset = 1'b0;
      push(1'b0, 0, 4'd2, 2'b00);
      push(1'b0, 1, 4'd4, 2'b00);
      @(negedge clk);
      chk("rst_tie_req0_ready", if1.req0_ready, 1);
      chk("rst_tie_req1_ready", if1.req1_ready, 0);
      tick();
      if1.req0_valid = 1'b0;
      accept1(1);
      wait_idle1();

      repeat (3) tick();
      chk("dut1_queue_empty", q1.size(), 0);
      chk("dut3_queue_empty", q3.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "watchdog expired");
   end
endmodule
